// File: rtl/ddr2_ex_pkg.sv
// ddr2_ex_pkg: shared state type, lane LFSR step and lane seed helpers
package ddr2_ex_pkg;
  typedef enum logic {IDLE, RUN} state_t;
  function automatic logic [7:0] lfsr_next(input logic [7:0] d);
    return {d[6], d[5], d[4], d[3] ^ d[7], d[2] ^ d[7], d[1] ^ d[7], d[0], d[7]};
  endfunction
  function automatic logic [7:0] lane_seed(input int unsigned seed, input int unsigned i);
    return 8'((seed + i) % 256);
  endfunction
endpackage

// File: rtl/application_selector_ddr2_sdram_ex_exp_lfsr8.sv
// application_selector_ddr2_sdram_ex_exp_lfsr8: per-lane expected-pattern LFSR
module application_selector_ddr2_sdram_ex_exp_lfsr8
  import ddr2_ex_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_load,
  input  logic       i_adv,
  input  logic [7:0] i_seed,
  output logic [7:0] o_q
);
  logic [7:0] r_q;
  always_ff @(posedge clk)
    if (reset || i_load) r_q <= i_seed;
    else if (i_adv) r_q <= lfsr_next(r_q);
  assign o_q = r_q;
endmodule

// File: rtl/application_selector_ddr2_sdram_ex_rd_checker.sv
// application_selector_ddr2_sdram_ex_rd_checker: compares read beats against regenerated LFSR lanes
module application_selector_ddr2_sdram_ex_rd_checker
  import ddr2_ex_pkg::*;
#(
  parameter int          DATA_WIDTH = 64,
  parameter int unsigned SEED       = 32,
  parameter int          CNT_W      = 16,
  localparam int         NB         = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  rd_valid,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [NB-1:0]         pnf_per_byte,
  output logic                  pnf,
  output logic [CNT_W-1:0]      err_cnt,
  output logic [CNT_W-1:0]      beat_cnt,
  output logic                  first_err_valid,
  output logic [CNT_W-1:0]      first_err_beat,
  output logic                  busy
);
  localparam logic [CNT_W-1:0] MAX = '1;
  state_t           r_state;
  logic             r_s1_valid, r_fev;
  logic [NB-1:0]    r_s1_mis, r_pnf, w_mis;
  logic [CNT_W-1:0] r_err, r_beat, r_feb;
  logic [7:0]       w_exp [NB];
  logic             w_acc;
  assign w_acc = (r_state == RUN) && rd_valid && !start;
  for (genvar i = 0; i < NB; i++) begin : g_lane
    application_selector_ddr2_sdram_ex_exp_lfsr8 u_lfsr (
      .clk   (clk),
      .reset (reset),
      .i_load(start),
      .i_adv (w_acc),
      .i_seed(lane_seed(SEED, i)),
      .o_q   (w_exp[i])
    );
    assign w_mis[i] = rd_data[8*i +: 8] != w_exp[i];
  end
  // start clears results exactly like reset, but lands in RUN and drops any in-flight beat
  always_ff @(posedge clk)
    if (reset || start) begin
      r_state    <= reset ? IDLE : RUN;
      r_s1_valid <= 1'b0;
      r_s1_mis   <= '0;
      r_pnf      <= '1;
      r_err      <= '0;
      r_beat     <= '0;
      r_feb      <= '0;
      r_fev      <= 1'b0;
    end else begin
      if (stop) r_state <= IDLE;
      r_s1_valid <= w_acc;
      r_s1_mis   <= w_mis;
      if (r_s1_valid) begin
        r_beat <= (r_beat == MAX) ? r_beat : r_beat + 1'b1;
        r_pnf  <= r_pnf & ~r_s1_mis;
        if (|r_s1_mis) begin
          r_err <= (r_err == MAX) ? r_err : r_err + 1'b1;
          if (!r_fev) begin
            r_fev <= 1'b1;
            r_feb <= r_beat;
          end
        end
      end
    end
  assign pnf_per_byte    = r_pnf;
  assign pnf             = &r_pnf;
  assign err_cnt         = r_err;
  assign beat_cnt        = r_beat;
  assign first_err_valid = r_fev;
  assign first_err_beat  = r_feb;
  assign busy            = (r_state == RUN) || r_s1_valid;
endmodule
